// File: rtl/dpram_fifo_ctrl.sv
// Synchronous FIFO controller driving an external dual-port RAM (port A writes, port B reads).
// Optional `DPRAM_FIFO_LEVEL_EN adds a registered fill-level output port `level`.
module dpram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  ram_we_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [DATA_WIDTH-1:0] ram_din_a,
    output logic                  ram_we_b,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    input  logic [DATA_WIDTH-1:0] ram_dout_b
`ifdef DPRAM_FIFO_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   level
`endif
);

    // Handshakes: a word moves on s_* when s_valid & s_ready, and on m_* when
    // m_valid & m_ready, at the rising edge; both sides may move in the same cycle.

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] wr_ptr_dly_q;
    logic                full;
    logic                push;
    logic                pop;

    // Full when the pointers share low bits but differ in the wrap bit.
    assign full = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                  (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);

    assign s_ready = !full;
    // Compare against the delayed write pointer so the RAM has had a full cycle
    // to register the newly written head word on port B.
    assign m_valid = (rd_ptr_q != wr_ptr_dly_q);

    assign push = s_valid && !full && !rst;
    assign pop  = m_valid && m_ready && !rst;

    assign wr_ptr_d = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, push};
    assign rd_ptr_d = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, pop};

    assign ram_we_a   = push;
    assign ram_addr_a = wr_ptr_q[ADDR_WIDTH-1:0];
    assign ram_din_a  = s_data;
    assign ram_we_b   = 1'b0;
    // Look-ahead read address keeps port B one step ahead, so m_data is the head word.
    assign ram_addr_b = rd_ptr_d[ADDR_WIDTH-1:0];
    assign m_data     = ram_dout_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_dly_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_dly_q <= wr_ptr_q;
        end
    end

`ifdef DPRAM_FIFO_LEVEL_EN
    logic [ADDR_WIDTH:0] level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= wr_ptr_d - rd_ptr_d;
        end
    end

    assign level = level_q;
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Self-checking bench for dpram_fifo_ctrl with a behavioural RAM on the storage ports.
// Reference model: a queue of words plus the edge each word was pushed on.
module tb_dpram_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          ram_we_a;
    logic [AW-1:0] ram_addr_a;
    logic [DW-1:0] ram_din_a;
    logic          ram_we_b;
    logic [AW-1:0] ram_addr_b;
    logic [DW-1:0] ram_dout_b;
`ifdef DPRAM_FIFO_LEVEL_EN
    logic [AW:0]   level;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wr_cnt   = 0;
    logic [DW-1:0] exp_q[$];
    int            edge_q[$];

    dpram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .ram_we_a   (ram_we_a),
        .ram_addr_a (ram_addr_a),
        .ram_din_a  (ram_din_a),
        .ram_we_b   (ram_we_b),
        .ram_addr_b (ram_addr_b),
        .ram_dout_b (ram_dout_b)
`ifdef DPRAM_FIFO_LEVEL_EN
        ,
        .level      (level)
`endif
    );

    // Behavioural dual-port RAM: registered read, old data on same-address read/write.
    logic [DW-1:0] mem [0:DEPTH-1];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'hDE;
        ram_dout_b = 8'hDE;
    end
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
        ram_dout_b <= mem[ram_addr_b];
    end

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time exceeded, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    // One cycle: apply inputs, compare against the model at the falling edge, advance.
    task automatic tick(input logic sv, input logic [DW-1:0] sd, input logic mr,
                        output logic popped, output logic [DW-1:0] pdata);
        logic exp_ready, exp_valid, push, pop;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        @(negedge clk);
        exp_ready = (exp_q.size() < DEPTH);
        exp_valid = 1'b0;
        if (exp_q.size() > 0) exp_valid = (edge_q[0] + 1 <= cyc);
        n_checks++;
        if (s_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL s_ready: got %b exp %b (cyc %0d)", s_ready, exp_ready, cyc);
        end
        n_checks++;
        if (m_valid !== exp_valid) begin
            n_fail++;
            $display("FAIL m_valid: got %b exp %b (cyc %0d)", m_valid, exp_valid, cyc);
        end
        if (exp_valid) begin
            n_checks++;
            if (m_data !== exp_q[0]) begin
                n_fail++;
                $display("FAIL m_data: got %h exp %h (cyc %0d)", m_data, exp_q[0], cyc);
            end
        end
        n_checks++;
        if (ram_we_a !== (sv && exp_ready)) begin
            n_fail++;
            $display("FAIL ram_we_a: got %b exp %b (cyc %0d)", ram_we_a, sv && exp_ready, cyc);
        end
        n_checks++;
        if (ram_addr_a !== AW'(wr_cnt % DEPTH)) begin
            n_fail++;
            $display("FAIL ram_addr_a: got %0d exp %0d (cyc %0d)", ram_addr_a, wr_cnt % DEPTH, cyc);
        end
        n_checks++;
        if (ram_din_a !== sd || ram_we_b !== 1'b0) begin
            n_fail++;
            $display("FAIL ram_din_we_b: got din %h we_b %b exp din %h we_b 0", ram_din_a, ram_we_b, sd);
        end
`ifdef DPRAM_FIFO_LEVEL_EN
        n_checks++;
        if (level !== (AW+1)'(exp_q.size())) begin
            n_fail++;
            $display("FAIL level: got %0d exp %0d (cyc %0d)", level, exp_q.size(), cyc);
        end
`endif
        push   = sv && exp_ready;
        pop    = exp_valid && mr;
        popped = pop;
        pdata  = m_data;
        if (pop) begin
            void'(exp_q.pop_front());
            void'(edge_q.pop_front());
        end
        @(posedge clk);
        cyc++;
        if (push) begin
            exp_q.push_back(sd);
            edge_q.push_back(cyc);
            wr_cnt++;
        end
        #1;
    endtask

    task automatic do_reset(input int n, input logic sv, input logic mr);
        rst     = 1'b1;
        s_valid = sv;
        s_data  = 8'hEE;
        m_ready = mr;
        repeat (n) @(posedge clk);
        cyc += n;
        #1;
        rst     = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        exp_q.delete();
        edge_q.delete();
        wr_cnt = 0;
        #1;
    endtask

    task automatic drain();
        logic p;
        logic [DW-1:0] d;
        int guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            tick(1'b0, 8'h00, 1'b1, p, d);
            guard++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d words left exp 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset(2, 1'b0, 1'b0);
        n_checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || ram_we_a !== 1'b0 ||
            ram_addr_a !== 2'd0 || ram_addr_b !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: got s_ready %b m_valid %b we_a %b addr_a %0d addr_b %0d exp 1 0 0 0 0",
                     s_ready, m_valid, ram_we_a, ram_addr_a, ram_addr_b);
        end
    endtask

    task automatic test_single();
        logic p;
        logic [DW-1:0] d;
        tick(1'b1, 8'hA5, 1'b1, p, d);
        n_checks++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early: got m_valid %b exp 0", m_valid);
        end
        tick(1'b0, 8'h00, 1'b1, p, d);
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_latency: got m_valid %b data %h exp 1 a5", m_valid, m_data);
        end
        tick(1'b0, 8'h00, 1'b1, p, d);
        n_checks++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_after: got m_valid %b exp 0", m_valid);
        end
    endtask

    task automatic test_fill();
        logic p;
        logic [DW-1:0] d;
        logic [DW-1:0] got[$];
        int at[$];
        for (int i = 1; i <= 5; i++) begin
            tick(1'b1, 8'(i), 1'b0, p, d);
            if (i == 4) begin
                n_checks++;
                if (s_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fill_full: got s_ready %b exp 0", s_ready);
                end
            end
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 8'h00, 1'b1, p, d);
            if (p) begin
                got.push_back(d);
                at.push_back(i);
            end
        end
        n_checks++;
        if (got.size() != 4) begin
            n_fail++;
            $display("FAIL fill_count: got %0d pops exp 4", got.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (got[k] !== 8'(k + 1) || at[k] != k) begin
                    n_fail++;
                    $display("FAIL fill_pop%0d: got %h at %0d exp %h at %0d", k, got[k], at[k], k + 1, k);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic p;
        logic [DW-1:0] d;
        logic [DW-1:0] got[$];
        int at[$];
        for (int i = 0; i < 40 && got.size() < 16; i++) begin
            tick(i < 16, 8'(i), 1'b1, p, d);
            if (p) begin
                got.push_back(d);
                at.push_back(i);
            end
        end
        n_checks++;
        if (got.size() != 16) begin
            n_fail++;
            $display("FAIL stream_count: got %0d words exp 16", got.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                n_checks++;
                if (got[k] !== 8'(k) || at[k] != k + 2) begin
                    n_fail++;
                    $display("FAIL stream_word%0d: got %h at %0d exp %h at %0d", k, got[k], at[k], k, k + 2);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic p;
        logic [DW-1:0] d;
        tick(1'b1, 8'h33, 1'b0, p, d);
        tick(1'b0, 8'h00, 1'b0, p, d);
        for (int i = 0; i < 5; i++) begin
            tick(i < 2, (i == 0) ? 8'h44 : 8'h55, 1'b0, p, d);
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== 8'h33) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got m_valid %b data %h exp 1 33", i, m_valid, m_data);
            end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        logic p;
        logic [DW-1:0] d;
        tick(1'b1, 8'hA1, 1'b0, p, d);
        tick(1'b1, 8'hA2, 1'b0, p, d);
        tick(1'b1, 8'hA3, 1'b0, p, d);
        tick(1'b0, 8'h00, 1'b0, p, d);
        do_reset(1, 1'b1, 1'b1);
        n_checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || ram_addr_a !== 2'd0) begin
            n_fail++;
            $display("FAIL midreset_state: got m_valid %b s_ready %b addr_a %0d exp 0 1 0",
                     m_valid, s_ready, ram_addr_a);
        end
`ifdef DPRAM_FIFO_LEVEL_EN
        n_checks++;
        if (level !== 3'd0) begin
            n_fail++;
            $display("FAIL midreset_level: got %0d exp 0", level);
        end
`endif
        s_valid = 1'b1;
        s_data  = 8'h77;
        #1;
        n_checks++;
        if (ram_we_a !== 1'b1 || ram_addr_a !== 2'd0) begin
            n_fail++;
            $display("FAIL midreset_push: got we_a %b addr_a %0d exp 1 0", ram_we_a, ram_addr_a);
        end
        tick(1'b1, 8'h77, 1'b1, p, d);
        tick(1'b0, 8'h00, 1'b1, p, d);
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h77) begin
            n_fail++;
            $display("FAIL midreset_data: got m_valid %b data %h exp 1 77", m_valid, m_data);
        end
        drain();
    endtask

    task automatic test_random();
        logic p;
        logic [DW-1:0] d;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0)
                do_reset(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                tick($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 65, p, d);
        end
        drain();
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        m_ready = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
